// File: rtl/svm_pkg.sv
// Definitions shared by the feature packer and the SVM classifier so both ends agree
// on the FSM encoding and on the feature-vector geometry.
package svm_pkg;

    typedef enum logic {
        FillState  = 1'b0,
        WriteState = 1'b1
    } state_t;

    localparam logic [15:0] PeriodNum = 16'd512;
    localparam logic [7:0]  LocalNum  = 8'd16;

endpackage

// File: rtl/svm_lane_packer.sv
// 128-bit word register with an 8-bit lane write port and a whole-word clear.
// The clear on every FIFO write is what leaves unfilled lanes zero after a flush.
module svm_lane_packer (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [3:0]   lane,
    input  logic [7:0]   data,
    input  logic         clear,
    output logic [127:0] word
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (wr_en) begin
            word[{lane, 3'b000} +: 8] <= data;
        end
    end

endmodule

// File: rtl/svm_feature_packer.sv
// Packs 8-bit feature samples into 128-bit FIFO words and counts words per object.
// Optional running byte checksum per frame: define SVM_PACKER_CHECKSUM_EN.
module svm_feature_packer
    import svm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic         flush,
    input  logic         wrfull,
    output logic         wrfifo,
    output logic [127:0] wrdata,
    output logic         frame_done,
    output logic [15:0]  wordcounteroutput,
    output logic [7:0]   localcounteroutput
`ifdef SVM_PACKER_CHECKSUM_EN
    ,
    output logic [31:0]  checksum
`endif
);

    state_t      state;
    logic [7:0]  local_counter;
    logic [15:0] period_counter;
    logic        accept;
    logic        go_write;
    logic        frame_end;

    // Gating with reset keeps the handshake and the write strobe quiet while reset is held.
    assign byte_ready = (state == FillState) & ce & reset;
    assign wrfifo     = (state == WriteState) & ~wrfull & ce & reset;
    assign accept     = byte_valid & byte_ready;

    // A flush that coincides with the 16th byte just closes the full word.
    assign go_write  = byte_ready &
                       ((accept & (local_counter == LocalNum - 8'd1)) |
                        (flush & (accept | (local_counter != 8'd0))));
    assign frame_end = wrfifo & (period_counter == PeriodNum - 16'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= FillState;
            local_counter  <= 8'd0;
            period_counter <= 16'd0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                local_counter <= local_counter + 8'd1;
            end
            if (go_write) begin
                state <= WriteState;
            end
            if (wrfifo) begin
                state          <= FillState;
                local_counter  <= 8'd0;
                period_counter <= frame_end ? 16'd0 : period_counter + 16'd1;
                frame_done     <= frame_end;
            end
        end
    end

    svm_lane_packer u_lane_packer (
        .clk   (clk),
        .reset (reset),
        .wr_en (accept),
        .lane  (local_counter[3:0]),
        .data  (byte_in),
        .clear (wrfifo),
        .word  (wrdata)
    );

    assign wordcounteroutput  = period_counter;
    assign localcounteroutput = local_counter;

`ifdef SVM_PACKER_CHECKSUM_EN
    logic [31:0] running_sum;

    // No byte can be accepted in WriteState, so the frame-end latch never misses one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            running_sum <= 32'd0;
            checksum    <= 32'd0;
        end else if (frame_end) begin
            checksum    <= running_sum;
            running_sum <= 32'd0;
        end else if (accept) begin
            running_sum <= running_sum + {24'd0, byte_in};
        end
    end
`endif

endmodule

// File: tb/tb_svm_feature_packer.sv
// Directed bench for svm_feature_packer: packing order, flush padding, FIFO back-pressure,
// clock enable, mid-word reset and the 512-word frame boundary.
module tb_svm_feature_packer;

    logic         clk;
    logic         reset;
    logic         ce;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         flush;
    logic         wrfull;
    logic         wrfifo;
    logic [127:0] wrdata;
    logic         frame_done;
    logic [15:0]  wordcounteroutput;
    logic [7:0]   localcounteroutput;
`ifdef SVM_PACKER_CHECKSUM_EN
    logic [31:0]  checksum;
`endif

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int fd_count = 0;

    svm_feature_packer dut (
        .clk                (clk),
        .reset              (reset),
        .ce                 (ce),
        .byte_in            (byte_in),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .flush              (flush),
        .wrfull             (wrfull),
        .wrfifo             (wrfifo),
        .wrdata             (wrdata),
        .frame_done         (frame_done),
        .wordcounteroutput  (wordcounteroutput),
        .localcounteroutput (localcounteroutput)
`ifdef SVM_PACKER_CHECKSUM_EN
        ,
        .checksum           (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wrfifo) wr_count <= wr_count + 1;
        if (frame_done) fd_count <= fd_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    initial begin
        int base_wr;
        int base_fd;
        logic [127:0] held;

        reset = 1'b0; ce = 1'b1; byte_in = 8'd0; byte_valid = 1'b0;
        flush = 1'b0; wrfull = 1'b0;
        tick(); tick();
        check("reset_byte_ready", byte_ready, 0);
        check("reset_wrfifo", wrfifo, 0);
        check("reset_wrdata", wrdata, 0);
        check("reset_wordcnt", wordcounteroutput, 0);
        check("reset_localcnt", localcounteroutput, 0);
        check("reset_frame_done", frame_done, 0);

        // Word of 0x00..0x0F
        reset = 1'b1;
        tick();
        check("ready_after_reset", byte_ready, 1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("w1_wrfifo", wrfifo, 1);
        check("w1_wrdata", wrdata, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        check("w1_localcnt", localcounteroutput, 16);
        tick();
        check("w1_wr_count", wr_count, 1);
        check("w1_wrfifo_drop", wrfifo, 0);
        check("w1_wordcnt", wordcounteroutput, 1);
        check("w1_local_clear", localcounteroutput, 0);
        check("w1_data_clear", wrdata, 0);

        // Flush with nothing held is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("empty_flush_ready", byte_ready, 1);
        check("empty_flush_wrfifo", wrfifo, 0);

        // Partial word with flush
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
        check("partial_localcnt", localcounteroutput, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wrfifo", wrfifo, 1);
        check("flush_wrdata", wrdata, 128'hA5A4A3A2A1);
        tick();
        check("flush_wr_count", wr_count, 2);
        check("flush_wordcnt", wordcounteroutput, 2);

        // Back-pressure from a full FIFO
        wrfull = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
        held = wrdata;
        check("full_data", held, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        for (int i = 0; i < 10; i++) begin
            byte_in = 8'h77; byte_valid = 1'b1;
            tick();
            check("full_wrfifo", wrfifo, 0);
            check("full_ready", byte_ready, 0);
            check("full_stable", wrdata, held);
        end
        byte_valid = 1'b0;
        wrfull = 1'b0;
        #1;
        check("full_release_wrfifo", wrfifo, 1);
        tick();
        check("full_wr_count", wr_count, 3);
        check("full_wordcnt", wordcounteroutput, 3);

        // Clock enable low mid-word
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        ce = 1'b0; byte_in = 8'hEE; byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce_ready", byte_ready, 0);
            check("ce_localcnt", localcounteroutput, 4);
        end
        ce = 1'b1; byte_valid = 1'b0;
        for (int i = 4; i < 16; i++) send_byte(8'h40 + 8'(i));
        check("ce_wrfifo", wrfifo, 1);
        check("ce_wrdata", wrdata, 128'h4F4E4D4C_4B4A4948_47464544_43424140);
        tick();
        check("ce_wordcnt", wordcounteroutput, 4);

        // Reset after 9 bytes discards the partial word
        base_wr = wr_count;
        for (int i = 0; i < 9; i++) send_byte(8'h90 + 8'(i));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_localcnt", localcounteroutput, 0);
        check("rst_wordcnt", wordcounteroutput, 0);
        check("rst_wrdata", wrdata, 0);
        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
        check("rst_no_write", wr_count - base_wr, 0);
        check("rst_word", wrdata, 128'h3F3E3D3C_3B3A3938_37363534_33323130);
        tick();
        check("rst_wr_count", wr_count - base_wr, 1);

        // Full frame of 512 words of 0xFF
        reset = 1'b0;
        tick();
        reset = 1'b1;
        base_wr = wr_count;
        base_fd = fd_count;
        byte_in = 8'hFF; byte_valid = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (wr_count - base_wr == 512) break;
        end
        byte_valid = 1'b0;
        check("frame_writes", wr_count - base_wr, 512);
        check("frame_no_early_done", fd_count - base_fd, 0);
        check("frame_done_pulse", frame_done, 1);
        check("frame_wordcnt_wrap", wordcounteroutput, 0);
`ifdef SVM_PACKER_CHECKSUM_EN
        check("frame_checksum", checksum, 32'(512 * 16 * 255));
`endif
        tick();
        check("frame_done_drop", frame_done, 0);
        check("frame_done_once", fd_count - base_fd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
